date_string_tx: RTL and testbench

Byte-serial ASCII date transmitter: holds a calendar date in BCD and, on each start request, emits it as the 10-character string "YYYY-MM-DD", one byte per clock, then advances the stored date by one day. It is the producer for the date-checking byte-stream receiver. Its `out` port connects directly to that receiver's `in` port, and idle cycles carry 0x00.

---
 rtl/date_string_tx.sv | 179 +++++++++++++++++
 tb/tb_date_string_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/date_string_tx.sv
// Byte-serial "YYYY-MM-DD" transmitter over a stored BCD date; one char per clock, then the date advances a day.
// Latency: first char one cycle after start; no backpressure, load/start ignored while busy.
module date_string_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] year_in,
    input  logic [7:0]  month_in,
    input  logic [7:0]  day_in,
    input  logic        start,
    output logic [7:0]  out,
    output logic        out_valid,
    output logic        busy,
    output logic        load_err,
    output logic [15:0] cur_year,
    output logic [7:0]  cur_month,
    output logic [7:0]  cur_day
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]  state;
    logic [3:0]  idx;
    logic [3:0]  nxt_idx;
    logic        load_ok;
    logic [7:0]  cur_dim;
    logic [15:0] nxt_year;
    logic [7:0]  nxt_month;
    logic [7:0]  nxt_day;

    function automatic logic div4(input logic [3:0] x, input logic [3:0] y);
        return (!x[0] && (y == 4'd0 || y == 4'd4 || y == 4'd8)) ||
               ( x[0] && (y == 4'd2 || y == 4'd6));
    endfunction

    // Century years fall back to the century digits, so 2000 leaps and 1900 does not.
    function automatic logic is_leap(input logic [15:0] yr);
        if (yr[7:0] != 8'h00)
            return div4(yr[7:4], yr[3:0]);
        else
            return div4(yr[15:12], yr[11:8]);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [15:0] yr);
        case (m)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: return 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      return 8'h30;
            8'h02:   return is_leap(yr) ? 8'h29 : 8'h28;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic all_bcd(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 9999 ripples through every digit and lands on 0000.
    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] char_at(input logic [3:0] i, input logic [15:0] y,
                                           input logic [7:0] m, input logic [7:0] d);
        case (i)
            4'd0:       return {4'h3, y[15:12]};
            4'd1:       return {4'h3, y[11:8]};
            4'd2:       return {4'h3, y[7:4]};
            4'd3:       return {4'h3, y[3:0]};
            4'd5:       return {4'h3, m[7:4]};
            4'd6:       return {4'h3, m[3:0]};
            4'd8:       return {4'h3, d[7:4]};
            4'd9:       return {4'h3, d[3:0]};
            4'd4, 4'd7: return 8'h2D;
            default:    return 8'h00;
        endcase
    endfunction

    // BCD values compare correctly as plain binary once every nibble is a digit.
    assign load_ok = all_bcd({year_in, month_in, day_in}) &&
                     month_in >= 8'h01 && month_in <= 8'h12 &&
                     day_in != 8'h00 && day_in <= days_in_month(month_in, year_in);

    assign cur_dim = days_in_month(cur_month, cur_year);
    assign nxt_idx = (state == IDLE) ? 4'd0 : idx + 4'd1;

    always_comb begin
        nxt_year  = cur_year;
        nxt_month = cur_month;
        nxt_day   = cur_day;
        if (cur_day < cur_dim) begin
            nxt_day = bcd2_inc(cur_day);
        end else begin
            nxt_day = 8'h01;
            if (cur_month == 8'h12) begin
                nxt_month = 8'h01;
                nxt_year  = bcd4_inc(cur_year);
            end else begin
                nxt_month = bcd2_inc(cur_month);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 4'd0;
            out       <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            load_err  <= 1'b0;
            cur_year  <= 16'h2000;
            cur_month <= 8'h01;
            cur_day   <= 8'h01;
        end else begin
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        if (load_ok) begin
                            cur_year  <= year_in;
                            cur_month <= month_in;
                            cur_day   <= day_in;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else if (start) begin
                        state     <= EMIT;
                        idx       <= nxt_idx;
                        out       <= char_at(nxt_idx, cur_year, cur_month, cur_day);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    if (idx == 4'd9) begin
                        state     <= IDLE;
                        idx       <= 4'd0;
                        out       <= 8'h00;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        cur_year  <= nxt_year;
                        cur_month <= nxt_month;
                        cur_day   <= nxt_day;
                    end else begin
                        idx <= nxt_idx;
                        out <= char_at(nxt_idx, cur_year, cur_month, cur_day);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_date_string_tx.sv
// Directed bench for date_string_tx: strings, day/month/year carries, load rejections, control priority.
module tb_date_string_tx;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] year_in;
    logic [7:0]  month_in;
    logic [7:0]  day_in;
    logic        start;
    logic [7:0]  out;
    logic        out_valid;
    logic        busy;
    logic        load_err;
    logic [15:0] cur_year;
    logic [7:0]  cur_month;
    logic [7:0]  cur_day;

    int checks = 0;
    int errors = 0;

    date_string_tx dut (
        .clk(clk), .reset(reset), .load(load), .year_in(year_in), .month_in(month_in),
        .day_in(day_in), .start(start), .out(out), .out_valid(out_valid), .busy(busy),
        .load_err(load_err), .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_date(input string tag, input logic [15:0] y, input logic [7:0] m,
                              input logic [7:0] d);
        check({tag, "_year"},  32'(cur_year),  32'(y));
        check({tag, "_month"}, 32'(cur_month), 32'(m));
        check({tag, "_day"},   32'(cur_day),   32'(d));
    endtask

    // Returns at the negedge of the cycle showing character 0.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks 10 characters, ends at the idle cycle after the string.
    task automatic expect_str(input string tag, input logic [79:0] s);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("%s_chr%0d", tag, k), 32'(out), 32'(s[79-8*k -: 8]));
            check($sformatf("%s_vld%0d", tag, k), 32'(out_valid), 32'd1);
            check($sformatf("%s_bsy%0d", tag, k), 32'(busy), 32'd1);
            @(negedge clk);
        end
        check({tag, "_end_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_end_out"}, 32'(out), 32'd0);
        check({tag, "_end_bsy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [15:0] y, input logic [7:0] m,
                           input logic [7:0] d, input logic exp_err);
        load = 1'b1; year_in = y; month_in = m; day_in = d;
        @(negedge clk);
        load = 1'b0;
        check({tag, "_err"}, 32'(load_err), 32'(exp_err));
        @(negedge clk);
        check({tag, "_err_clr"}, 32'(load_err), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0;
        year_in = 16'h0; month_in = 8'h0; day_in = 8'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_bsy", 32'(busy), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check_date("rst", 16'h2000, 8'h01, 8'h01);

        do_start();
        expect_str("s2000", "2000-01-01");
        check_date("d2000", 16'h2000, 8'h01, 8'h02);

        do_load("l2012", 16'h2012, 8'h02, 8'h28, 1'b0);
        check_date("l2012", 16'h2012, 8'h02, 8'h28);
        do_start();
        expect_str("s2012a", "2012-02-28");
        do_start();
        expect_str("s2012b", "2012-02-29");
        check_date("d2012", 16'h2012, 8'h03, 8'h01);

        do_load("l1900", 16'h1900, 8'h02, 8'h28, 1'b0);
        do_start();
        expect_str("s1900", "1900-02-28");
        check_date("d1900", 16'h1900, 8'h03, 8'h01);
        do_load("bad1900", 16'h1900, 8'h02, 8'h29, 1'b1);
        check_date("bad1900", 16'h1900, 8'h03, 8'h01);

        do_load("l9999", 16'h9999, 8'h12, 8'h31, 1'b0);
        do_start();
        expect_str("s9999", "9999-12-31");
        check_date("d9999", 16'h0000, 8'h01, 8'h01);
        do_start();
        expect_str("s0000", "0000-01-01");
        check_date("d0000", 16'h0000, 8'h01, 8'h02);

        do_load("bad_m13", 16'h2021, 8'h13, 8'h01, 1'b1);
        do_load("bad_a31", 16'h2021, 8'h04, 8'h31, 1'b1);
        do_load("bad_0a",  16'h2021, 8'h0A, 8'h01, 1'b1);
        do_load("bad_m00", 16'h2021, 8'h00, 8'h10, 1'b1);
        check_date("bad_all", 16'h0000, 8'h01, 8'h02);

        do_load("l2021", 16'h2021, 8'h04, 8'h30, 1'b0);
        do_start();
        expect_str("s2021", "2021-04-30");
        check_date("d2021", 16'h2021, 8'h05, 8'h01);

        // start held high: exactly one idle cycle between strings
        start = 1'b1;
        @(negedge clk);
        expect_str("held", "2021-05-01");
        @(negedge clk);
        start = 1'b0;
        check("held_next_chr", 32'(out), 32'h32);
        check("held_next_vld", 32'(out_valid), 32'd1);
        wait_idle("held");
        check_date("held", 16'h2021, 8'h05, 8'h03);

        do_start();
        @(negedge clk);
        @(negedge clk);
        load = 1'b1; year_in = 16'h2030; month_in = 8'h06; day_in = 8'h15;
        @(negedge clk);
        load = 1'b0;
        check("emitload_err", 32'(load_err), 32'd0);
        wait_idle("emitload");
        check_date("emitload", 16'h2021, 8'h05, 8'h04);

        load = 1'b1; start = 1'b1; year_in = 16'h2024; month_in = 8'h02; day_in = 8'h29;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        check("ldst_bsy", 32'(busy), 32'd0);
        check("ldst_vld", 32'(out_valid), 32'd0);
        check_date("ldst", 16'h2024, 8'h02, 8'h29);
        @(negedge clk);
        check("ldst_bsy2", 32'(busy), 32'd0);
        do_start();
        expect_str("s2024", "2024-02-29");
        check_date("d2024", 16'h2024, 8'h03, 8'h01);

        do_start();
        repeat (4) @(negedge clk);
        check("rst4_chr", 32'(out), 32'h2D);
        reset = 1'b1;
        #1;
        check("rst4_vld", 32'(out_valid), 32'd0);
        check("rst4_out", 32'(out), 32'd0);
        check("rst4_bsy", 32'(busy), 32'd0);
        check_date("rst4", 16'h2000, 8'h01, 8'h01);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_vld", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
